jailbreak_bus_initiator: RTL and testbench

- Initiator (master) end of the jailbreak bus: it drives addr/wr/wr_data/rd and consumes rd_data/rd_data_valid from register responders such as the DIP-switch block.
- Accepts one command at a time from a local sequencer or host over a valid/ready handshake.
- Issues a single-cycle bus strobe for each command.
- Returns one response per command over a second valid/ready handshake, with a timeout on reads.

---
 rtl/jailbreak_bus_initiator_pkg.sv | 31 +++
 rtl/jailbreak_timeout_counter.sv | 43 ++++
 rtl/jailbreak_bus_initiator.sv | 213 +++++++++++++++++++++
 tb/tb_jailbreak_bus_initiator.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jailbreak_bus_initiator_pkg.sv
// Shared types and constants for the jailbreak bus initiator.
// The command/response records describe the bus at its default 32-bit width.
// Sequencer-side code uses them to build and unpack transactions.
package jailbreak_bus_initiator_pkg;

    localparam int BUS_ADDR_WIDTH      = 32;
    localparam int BUS_DATA_WIDTH      = 32;
    localparam int TIMEOUT_COUNT_WIDTH = 8;

    // Read data returned when a responder never answers.
    localparam logic [31:0] BUS_TIMEOUT_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } initiator_state_t;

    typedef struct packed {
        logic                      write;
        logic [BUS_ADDR_WIDTH-1:0] addr;
        logic [BUS_DATA_WIDTH-1:0] wr_data;
    } bus_cmd_t;

    typedef struct packed {
        logic [BUS_DATA_WIDTH-1:0] rd_data;
        logic                      timeout;
    } bus_rsp_t;

endpackage

// File: rtl/jailbreak_timeout_counter.sv
// Read-timeout counter for the jailbreak bus initiator.
// The counter is cleared while the read strobe is issued and counts every
// cycle the initiator waits. It flags expiry on the wait cycle where the
// count equals LIMIT-1. LIMIT must lie in 2..255.
module jailbreak_timeout_counter
    import jailbreak_bus_initiator_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TIMEOUT_COUNT_WIDTH-1:0] LAST_COUNT = TIMEOUT_COUNT_WIDTH'(LIMIT - 1);

    logic [TIMEOUT_COUNT_WIDTH-1:0] count_q;
    logic [TIMEOUT_COUNT_WIDTH-1:0] count_d;

    // Clear has priority; otherwise count up while the initiator is waiting.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/jailbreak_bus_initiator.sv
// Initiator (master) end of the jailbreak bus.
// Takes one command at a time, issues a single-cycle bus strobe, and returns
// one response per command. Reads that get no rd_data_valid within
// TIMEOUT_CYCLES wait cycles complete with TIMEOUT_DATA and rsp_timeout set.
// Optional statistics counters: define JAILBREAK_INITIATOR_STATS_EN.
module jailbreak_bus_initiator
    import jailbreak_bus_initiator_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = DATA_WIDTH'(BUS_TIMEOUT_DATA)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wr_data_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rd_data_o,
    output logic                  rsp_timeout_o,

    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic                  bus_wr_o,
    output logic [DATA_WIDTH-1:0] bus_wr_data_o,
    output logic                  bus_rd_o,
    input  logic [DATA_WIDTH-1:0] bus_rd_data_i,
    input  logic                  bus_rd_data_valid_i,

    output logic [15:0]           stat_txn_count_o,
    output logic [15:0]           stat_timeout_count_o
);

    initiator_state_t      state_q;
    initiator_state_t      state_d;

    logic                  write_q;
    logic                  write_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q;
    logic [ADDR_WIDTH-1:0] bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wr_data_q;
    logic [DATA_WIDTH-1:0] bus_wr_data_d;
    logic [DATA_WIDTH-1:0] rsp_rd_data_q;
    logic [DATA_WIDTH-1:0] rsp_rd_data_d;
    logic                  rsp_timeout_q;
    logic                  rsp_timeout_d;

    logic                  timer_clear;
    logic                  timer_enable;
    logic                  timer_expired;

    jailbreak_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (timer_clear),
        .enable_i  (timer_enable),
        .expired_o (timer_expired)
    );

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one command in flight, no overlap with the response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = write_q ? RESP : RD_WAIT;
            end
            RD_WAIT: begin
                if (bus_rd_data_valid_i || timer_expired) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: strobes only in ISSUE, response valid only in RESP.
    always_comb begin
        cmd_ready_o  = (state_q == IDLE) && !reset_i;
        bus_wr_o     = (state_q == ISSUE) && write_q;
        bus_rd_o     = (state_q == ISSUE) && !write_q;
        rsp_valid_o  = (state_q == RESP);
        timer_clear  = (state_q == ISSUE);
        timer_enable = (state_q == RD_WAIT);
    end

    // Datapath next values: latch the command on accept, capture the response
    // when the transaction completes, hold everything otherwise.
    always_comb begin
        write_d       = write_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        rsp_rd_data_d = rsp_rd_data_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    write_d       = cmd_write_i;
                    bus_addr_d    = cmd_addr_i;
                    bus_wr_data_d = cmd_wr_data_i;
                end
            end
            ISSUE: begin
                if (write_q) begin
                    rsp_rd_data_d = '0;
                    rsp_timeout_d = 1'b0;
                end
            end
            RD_WAIT: begin
                if (bus_rd_data_valid_i) begin
                    rsp_rd_data_d = bus_rd_data_i;
                    rsp_timeout_d = 1'b0;
                end else if (timer_expired) begin
                    rsp_rd_data_d = TIMEOUT_DATA;
                    rsp_timeout_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            write_q       <= 1'b0;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            rsp_rd_data_q <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            write_q       <= write_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            rsp_rd_data_q <= rsp_rd_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus_addr_o    = bus_addr_q;
    assign bus_wr_data_o = bus_wr_data_q;
    assign rsp_rd_data_o = rsp_rd_data_q;
    assign rsp_timeout_o = rsp_timeout_q;

`ifdef JAILBREAK_INITIATOR_STATS_EN
    logic        rsp_handshake;
    logic [15:0] stat_txn_q;
    logic [15:0] stat_txn_d;
    logic [15:0] stat_timeout_q;
    logic [15:0] stat_timeout_d;

    assign rsp_handshake = rsp_valid_o && rsp_ready_i;

    // Saturating counts of completed responses and of timed-out ones.
    always_comb begin
        stat_txn_d     = stat_txn_q;
        stat_timeout_d = stat_timeout_q;
        if (rsp_handshake) begin
            if (stat_txn_q != 16'hFFFF) begin
                stat_txn_d = stat_txn_q + 16'd1;
            end
            if (rsp_timeout_q && (stat_timeout_q != 16'hFFFF)) begin
                stat_timeout_d = stat_timeout_q + 16'd1;
            end
        end
    end

    // Statistics registers, cleared on reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_txn_q     <= '0;
            stat_timeout_q <= '0;
        end else begin
            stat_txn_q     <= stat_txn_d;
            stat_timeout_q <= stat_timeout_d;
        end
    end

    assign stat_txn_count_o     = stat_txn_q;
    assign stat_timeout_count_o = stat_timeout_q;
`else
    assign stat_txn_count_o     = '0;
    assign stat_timeout_count_o = '0;
`endif

endmodule

// File: tb/tb_jailbreak_bus_initiator.sv
// Self-checking bench for jailbreak_bus_initiator.
// A table of directed transactions is run against a small register-file
// responder model with programmable read latency (0 = silent), followed by
// hand-written sequences for back-pressure, stray valids and mid-read reset.
// Statistics checks follow JAILBREAK_INITIATOR_STATS_EN.
module tb_jailbreak_bus_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmdValid;
    logic        cmdReady;
    logic        cmdWrite;
    logic [31:0] cmdAddr;
    logic [31:0] cmdWrData;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspRdData;
    logic        rspTimeout;
    logic [31:0] busAddr;
    logic        busWr;
    logic [31:0] busWrData;
    logic        busRd;
    logic [31:0] busRdData;
    logic        busRdDataValid;
    logic [15:0] statTxn;
    logic [15:0] statTimeout;

    jailbreak_bus_initiator #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16),
        .TIMEOUT_DATA   (32'hFFFF_FFFF)
    ) dut (
        .clk_i                (clk),
        .reset_i              (reset),
        .cmd_valid_i          (cmdValid),
        .cmd_ready_o          (cmdReady),
        .cmd_write_i          (cmdWrite),
        .cmd_addr_i           (cmdAddr),
        .cmd_wr_data_i        (cmdWrData),
        .rsp_valid_o          (rspValid),
        .rsp_ready_i          (rspReady),
        .rsp_rd_data_o        (rspRdData),
        .rsp_timeout_o        (rspTimeout),
        .bus_addr_o           (busAddr),
        .bus_wr_o             (busWr),
        .bus_wr_data_o        (busWrData),
        .bus_rd_o             (busRd),
        .bus_rd_data_i        (busRdData),
        .bus_rd_data_valid_i  (busRdDataValid),
        .stat_txn_count_o     (statTxn),
        .stat_timeout_count_o (statTimeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wrData;
        int          latency;
        int          readyDelay;
        logic [31:0] expData;
        bit          expTimeout;
        int          expRspCycle;
    } vec_t;

    localparam int NUM_VECS = 10;
    vec_t vecs[NUM_VECS];

    logic [31:0] mem[64];
    int          pending;
    logic [31:0] pendAddr;
    int          respLatency;
    bit          strayPulse;
    int          wrPulses;
    int          rdPulses;
    int          overlap;
    int          assertions;
    int          failures;
    int          expTxn;
    int          expTo;

    // Compare one observed value against its required value.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Advance one clock, then play the responder model and tally strobes.
    task automatic applyStimulus();
        logic        sawRd;
        logic        sawWr;
        logic [31:0] a;
        logic [31:0] d;
        sawRd = busRd;
        sawWr = busWr;
        a     = busAddr;
        d     = busWrData;
        @(posedge clk);
        #1;
        if (sawWr === 1'b1) mem[a[5:0]] = d;
        if (sawRd === 1'b1) begin
            pending  = respLatency;
            pendAddr = a;
        end
        busRdDataValid = 1'b0;
        busRdData      = 32'h0;
        if (pending > 0) begin
            pending--;
            if (pending == 0) begin
                busRdDataValid = 1'b1;
                busRdData      = mem[pendAddr[5:0]];
            end
        end
        if (strayPulse) begin
            busRdDataValid = 1'b1;
            busRdData      = 32'h5555_AAAA;
            strayPulse     = 1'b0;
        end
        if (busWr === 1'b1) wrPulses++;
        if (busRd === 1'b1) rdPulses++;
        if (busWr === 1'b1 && busRd === 1'b1) overlap++;
    endtask

    // Run one table entry from accept to response handshake.
    task automatic runTxn(input vec_t v);
        int          waitCnt;
        int          cycle;
        int          unstable;
        logic [31:0] heldData;
        logic        heldTo;
        wrPulses = 0;
        rdPulses = 0;
        overlap  = 0;
        respLatency = v.latency;
        waitCnt = 0;
        while (cmdReady !== 1'b1 && waitCnt < 10) begin
            applyStimulus();
            waitCnt++;
        end
        checkOutput({v.name, ".cmdReady"}, 64'(cmdReady), 64'd1);
        cmdValid  = 1'b1;
        cmdWrite  = v.write;
        cmdAddr   = v.addr;
        cmdWrData = v.wrData;
        applyStimulus();
        cmdValid = 1'b0;
        cycle = 1;
        checkOutput({v.name, ".strobe"}, 64'(v.write ? busWr : busRd), 64'd1);
        checkOutput({v.name, ".busAddr"}, 64'(busAddr), 64'(v.addr));
        if (v.write) checkOutput({v.name, ".busWrData"}, 64'(busWrData), 64'(v.wrData));
        while (rspValid !== 1'b1 && cycle < 40) begin
            applyStimulus();
            cycle++;
        end
        checkOutput({v.name, ".rspCycle"}, 64'(cycle), 64'(v.expRspCycle));
        checkOutput({v.name, ".rdData"}, 64'(rspRdData), 64'(v.expData));
        checkOutput({v.name, ".timeout"}, 64'(rspTimeout), 64'(v.expTimeout));
        heldData = rspRdData;
        heldTo   = rspTimeout;
        unstable = 0;
        for (int i = 0; i < v.readyDelay; i++) begin
            applyStimulus();
            if (rspValid !== 1'b1 || cmdReady !== 1'b0 || rspRdData !== heldData || rspTimeout !== heldTo) unstable++;
        end
        if (v.readyDelay > 0) checkOutput({v.name, ".heldStable"}, 64'(unstable), 64'd0);
        rspReady = 1'b1;
        expTxn++;
        if (v.expTimeout) expTo++;
        applyStimulus();
        rspReady = 1'b0;
        checkOutput({v.name, ".rspDone"}, 64'(rspValid), 64'd0);
        checkOutput({v.name, ".wrPulses"}, 64'(wrPulses), 64'(v.write ? 1 : 0));
        checkOutput({v.name, ".rdPulses"}, 64'(rdPulses), 64'(v.write ? 0 : 1));
        checkOutput({v.name, ".overlap"}, 64'(overlap), 64'd0);
    endtask

    // Statistics ports against the bench's own handshake tally.
    task automatic checkStats(input string tag);
`ifdef JAILBREAK_INITIATOR_STATS_EN
        checkOutput({tag, ".statTxn"}, 64'(statTxn), 64'(expTxn));
        checkOutput({tag, ".statTimeout"}, 64'(statTimeout), 64'(expTo));
`else
        checkOutput({tag, ".statTxn"}, 64'(statTxn), 64'd0);
        checkOutput({tag, ".statTimeout"}, 64'(statTimeout), 64'd0);
`endif
    endtask

    // All outputs at their reset values.
    task automatic checkResetState(input string tag);
        checkOutput({tag, ".cmdReady"}, 64'(cmdReady), 64'd0);
        checkOutput({tag, ".rspValid"}, 64'(rspValid), 64'd0);
        checkOutput({tag, ".busWr"}, 64'(busWr), 64'd0);
        checkOutput({tag, ".busRd"}, 64'(busRd), 64'd0);
        checkOutput({tag, ".busAddr"}, 64'(busAddr), 64'd0);
        checkOutput({tag, ".busWrData"}, 64'(busWrData), 64'd0);
        checkOutput({tag, ".rdData"}, 64'(rspRdData), 64'd0);
        checkOutput({tag, ".timeout"}, 64'(rspTimeout), 64'd0);
        checkStats(tag);
    endtask

    initial begin
        int seen;
        assertions = 0;
        failures   = 0;
        expTxn     = 0;
        expTo      = 0;
        pending    = 0;
        pendAddr   = 32'h0;
        respLatency = 1;
        strayPulse = 1'b0;
        wrPulses = 0;
        rdPulses = 0;
        overlap  = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        //            name        wr    addr          wrData        lat rdy expData       to  rspCyc
        vecs[0] = '{"wr10",     1'b1, 32'h0000_0010, 32'h0000_00A5, 1, 0, 32'h0000_0000, 1'b0, 2};
        vecs[1] = '{"wr4",      1'b1, 32'h0000_0004, 32'h0000_0003, 1, 0, 32'h0000_0000, 1'b0, 2};
        vecs[2] = '{"rd4",      1'b0, 32'h0000_0004, 32'h0000_0000, 1, 0, 32'h0000_0003, 1'b0, 3};
        vecs[3] = '{"rd10",     1'b0, 32'h0000_0010, 32'h0000_0000, 1, 1, 32'h0000_00A5, 1'b0, 3};
        vecs[4] = '{"rdSilent", 1'b0, 32'h0000_0008, 32'h0000_0000, 0, 0, 32'hFFFF_FFFF, 1'b1, 18};
        vecs[5] = '{"rdExpiry", 1'b0, 32'h0000_0010, 32'h0000_0000, 16, 0, 32'h0000_00A5, 1'b0, 18};
        vecs[6] = '{"rdLate",   1'b0, 32'h0000_0004, 32'h0000_0000, 17, 2, 32'hFFFF_FFFF, 1'b1, 18};
        vecs[7] = '{"rdLat3",   1'b0, 32'h0000_0004, 32'h0000_0000, 3, 0, 32'h0000_0003, 1'b0, 5};
        vecs[8] = '{"wr0",      1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 1, 0, 32'h0000_0000, 1'b0, 2};
        vecs[9] = '{"rd0",      1'b0, 32'h0000_0000, 32'h0000_0000, 2, 0, 32'hDEAD_BEEF, 1'b0, 4};

        reset          = 1'b1;
        cmdValid       = 1'b0;
        cmdWrite       = 1'b0;
        cmdAddr        = 32'h0;
        cmdWrData      = 32'h0;
        rspReady       = 1'b0;
        busRdData      = 32'h0;
        busRdDataValid = 1'b0;

        // Power-on reset.
        applyStimulus();
        applyStimulus();
        checkResetState("reset");
        reset = 1'b0;
        applyStimulus();
        checkOutput("reset.readyAfter", 64'(cmdReady), 64'd1);

        // A stray rd_data_valid while idle must not start anything.
        strayPulse = 1'b1;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("strayIdle.rspValid", 64'(rspValid), 64'd0);
        checkOutput("strayIdle.cmdReady", 64'(cmdReady), 64'd1);

        // Directed transaction table.
        for (int i = 0; i < NUM_VECS; i++) runTxn(vecs[i]);
        checkStats("table");

        // Back-pressure: response held for 5 cycles, next command waiting.
        respLatency = 1;
        wrPulses = 0;
        cmdValid  = 1'b1;
        cmdWrite  = 1'b1;
        cmdAddr   = 32'h0000_0020;
        cmdWrData = 32'h0000_0011;
        applyStimulus();
        cmdAddr   = 32'h0000_0024;
        cmdWrData = 32'h0000_0022;
        applyStimulus();
        checkOutput("bp.rspValid", 64'(rspValid), 64'd1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (rspValid !== 1'b1 || cmdReady !== 1'b0 || rspRdData !== 32'h0 || rspTimeout !== 1'b0) seen++;
            applyStimulus();
        end
        checkOutput("bp.heldStable", 64'(seen), 64'd0);
        checkOutput("bp.stillBlocked", 64'(cmdReady), 64'd0);
        rspReady = 1'b1;
        expTxn++;
        applyStimulus();
        rspReady = 1'b0;
        checkOutput("bp.readyNext", 64'(cmdReady), 64'd1);
        applyStimulus();
        cmdValid = 1'b0;
        checkOutput("bp.nextStrobe", 64'(busWr), 64'd1);
        checkOutput("bp.nextAddr", 64'(busAddr), 64'h24);
        checkOutput("bp.nextData", 64'(busWrData), 64'h22);
        applyStimulus();
        checkOutput("bp.nextRsp", 64'(rspValid), 64'd1);
        rspReady = 1'b1;
        expTxn++;
        applyStimulus();
        rspReady = 1'b0;
        checkOutput("bp.wrPulses", 64'(wrPulses), 64'd2);

        // Reset in the middle of a read wait, with responder valids afterwards.
        respLatency = 0;
        cmdValid = 1'b1;
        cmdWrite = 1'b0;
        cmdAddr  = 32'h0000_0004;
        applyStimulus();
        cmdValid = 1'b0;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        reset = 1'b1;
        strayPulse = 1'b1;
        applyStimulus();
        expTxn = 0;
        expTo  = 0;
        checkResetState("midReset");
        strayPulse = 1'b1;
        applyStimulus();
        reset = 1'b0;
        seen = 0;
        wrPulses = 0;
        rdPulses = 0;
        for (int i = 0; i < 20; i++) begin
            strayPulse = (i % 2) == 0;
            applyStimulus();
            if (rspValid !== 1'b0 || cmdReady !== 1'b1) seen++;
        end
        checkOutput("midReset.quiet", 64'(seen), 64'd0);
        checkOutput("midReset.noStrobes", 64'(wrPulses + rdPulses), 64'd0);

        // Normal operation resumes after the abort.
        runTxn(vecs[0]);
        runTxn(vecs[4]);
        checkStats("final");

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
